dot_prod_feeder: RTL and testbench
==================================

// Module: dot_prod_feeder
// PURPOSE
//  Upstream driver for the generated dot-product core (ports clk/r_enable/controlArr/arr a,b).
//  - Accepts a stream of (a,b) element pairs over a valid/ready handshake.
//  - Writes them into the core's arrays a/b through the controlArr write ports.
//  - Releases the core, waits for its w_enable, then returns the result over a valid/ready output handshake.
//  - One job is N pairs, followed by one result.
// PARAMETERS
//  N        1000   elements per job; must equal the core's array depth
//  AW       10     address width, >= clog2(N)
//  DW       27     signed element width
//  RW       64     signed result width
//  TMO      65535  max cycles in RUN before the job is abandoned
// PORTS
//  clk              in   1   clock, all logic on posedge
//  rst_n            in   1   synchronous reset, active low
//  in_valid         in   1   pair valid
//  in_ready         out  1   feeder accepts pair
//  in_a             in   DW  element of a (signed)
//  in_b             in   DW  element of b (signed)
//  out_valid        out  1   result valid
//  out_ready        in   1   consumer takes result
//  out_result       out  RW  dot product (signed)
//  out_timeout      out  1   qualifies out_valid: job abandoned, out_result=0
//  busy             out  1   state != LOAD or addr != 0
//  core_r_enable    out  1   to core r_enable
//  core_controlArr  out  1   to core controlArr
//  core_init_i      out  AW  constant 0
//  core_init_acc    out  RW  constant 0
//  core_wen_a/_b    out  1   to controlArrWEnable_a/_b
//  core_addr_a/_b   out  AW  to controlArrAddr_a/_b
//  core_wdata_a/_b  out  DW  to controlArrWData_a/_b
//  core_w_enable    in   1   from core w_enable
//  core_result      in   RW  from core result
// BEHAVIOUR
//  Reset values (rst_n=0 at posedge):
//  - state=LOAD, addr=0, tmo_cnt=0.
//  - out_valid=0, out_timeout=0, out_result=0.
//  - core_r_enable=1, core_controlArr=1, core_wen_*=0.
//  FSM LOAD -> RUN -> HOLD -> LOAD; all core_* outputs are registered.
//  LOAD:
//  - in_ready=1, core_r_enable=1 (core held parked), core_controlArr=1.
//  - On in_valid&&in_ready: next cycle core_wen_a=core_wen_b=1, addr_a=addr_b=addr,
//    wdata=in_a/in_b; addr++.
//  - Accepting pair addr==N-1: addr wraps to 0; next state RUN.
//  - No valid: core_wen_*=0, addr held.
//  RUN:
//  - in_ready=0, core_controlArr=0, core_r_enable=0, core_wen_*=0; tmo_cnt++ per cycle.
//  - Last write (entry cycle) and r_enable falling happen on the same edge; the core
//    reads arrays no earlier than 2 cycles later.
//  - core_w_enable is already 0 on entry (forced while parked); no stale done.
//  - core_w_enable=1: out_result<=core_result, out_valid<=1, out_timeout<=0,
//    core_r_enable<=1, state HOLD.
//  - tmo_cnt==TMO-1 without done: out_result<=0, out_timeout<=1, out_valid<=1, core_r_enable<=1, HOLD.
//  HOLD:
//  - in_ready=0; out_* stable while out_valid&&!out_ready.
//  - out_ready=1: out_valid<=0, out_timeout<=0, tmo_cnt<=0, core_controlArr<=1, state LOAD.
//  Arithmetic: addr compares full AW bits against N-1; core_result passes through, no resizing.
//  Reset mid-job: all state lost, core re-parked next edge, partial array contents
//  overwritten by the next job.
//  Simultaneous done and timeout in the same cycle: done wins.
// STRUCTURE
//  Package dot_prod_pkg: N, AW, DW, RW defaults; typedef enum logic[1:0] {LOAD,RUN,HOLD} feeder_state_t.
//  Single module, no sub-modules. Bench instantiates the feeder with the core.
// TESTING
//  1 a[i]=i+1, b[i]=2 for i<1000, in_valid always 1 -> 1000 writes, out_result=1001000, out_timeout=0.
//  2 in_valid toggled 1/0 every cycle, a=-3, b=5 -> addr advances only on accept, result=-15000.
//  3 out_ready=0 for 20 cycles after out_valid -> out_result/out_valid stable; in_ready=0 until accepted.
//  4 Core stub never raises w_enable, TMO=16 -> out_valid with out_timeout=1, out_result=0 at RUN cycle 16.
//  5 rst_n=0 after 500 pairs, then a full job a=b=1 -> result=1000, no carry-over from the aborted job.
//  6 Two back-to-back jobs a=b=1, then a=1, b=-1 -> results 1000, -1000; in_ready low for RUN and HOLD.

Source files
------------

// File: rtl/dot_prod_pkg.sv
// Shared defaults and state encoding for the dot-product core feeder.
package dot_prod_pkg;

    localparam int DP_N   = 1000;
    localparam int DP_AW  = 10;
    localparam int DP_DW  = 27;
    localparam int DP_RW  = 64;
    localparam int DP_TMO = 65535;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/dot_prod_feeder.sv
// Streams N (a,b) pairs into the dot-product core arrays, releases the core,
// and hands back its result (or a timeout marker) over a valid/ready port.
module dot_prod_feeder
    import dot_prod_pkg::*;
#(
    parameter int N   = DP_N,
    parameter int AW  = DP_AW,
    parameter int DW  = DP_DW,
    parameter int RW  = DP_RW,
    parameter int TMO = DP_TMO
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_result,
    output logic          out_timeout,
    output logic          busy,
    output logic          core_r_enable,
    output logic          core_controlArr,
    output logic [AW-1:0] core_init_i,
    output logic [RW-1:0] core_init_acc,
    output logic          core_wen_a,
    output logic          core_wen_b,
    output logic [AW-1:0] core_addr_a,
    output logic [AW-1:0] core_addr_b,
    output logic [DW-1:0] core_wdata_a,
    output logic [DW-1:0] core_wdata_b,
    input  logic          core_w_enable,
    input  logic [RW-1:0] core_result
);

    localparam int TW = $clog2(TMO + 1);

    feeder_state_t state_reg;
    logic [AW-1:0] addr_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          out_valid_reg;
    logic          out_timeout_reg;
    logic [RW-1:0] out_result_reg;
    logic          r_enable_reg;
    logic          control_arr_reg;
    logic          wen_reg;
    logic [AW-1:0] waddr_reg;
    logic [DW-1:0] wdata_a_reg;
    logic [DW-1:0] wdata_b_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= LOAD;
            addr_reg        <= '0;
            tmo_cnt_reg     <= '0;
            out_valid_reg   <= 1'b0;
            out_timeout_reg <= 1'b0;
            out_result_reg  <= '0;
            r_enable_reg    <= 1'b1;
            control_arr_reg <= 1'b1;
            wen_reg         <= 1'b0;
            waddr_reg       <= '0;
            wdata_a_reg     <= '0;
            wdata_b_reg     <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    r_enable_reg    <= 1'b1;
                    control_arr_reg <= 1'b1;
                    wen_reg         <= in_valid;
                    if (in_valid) begin
                        waddr_reg   <= addr_reg;
                        wdata_a_reg <= in_a;
                        wdata_b_reg <= in_b;
                        if (addr_reg == AW'(N - 1)) begin
                            addr_reg  <= '0;
                            state_reg <= RUN;
                        end else begin
                            addr_reg <= addr_reg + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The final write retires on the same edge that releases the core.
                    wen_reg         <= 1'b0;
                    control_arr_reg <= 1'b0;
                    if (core_w_enable) begin
                        out_result_reg  <= core_result;
                        out_valid_reg   <= 1'b1;
                        out_timeout_reg <= 1'b0;
                        r_enable_reg    <= 1'b1;
                        state_reg       <= HOLD;
                    end else if (tmo_cnt_reg == TW'(TMO - 1)) begin
                        out_result_reg  <= '0;
                        out_valid_reg   <= 1'b1;
                        out_timeout_reg <= 1'b1;
                        r_enable_reg    <= 1'b1;
                        state_reg       <= HOLD;
                    end else begin
                        r_enable_reg <= 1'b0;
                        tmo_cnt_reg  <= tmo_cnt_reg + 1'b1;
                    end
                end
                HOLD: begin
                    wen_reg <= 1'b0;
                    if (out_ready) begin
                        out_valid_reg   <= 1'b0;
                        out_timeout_reg <= 1'b0;
                        tmo_cnt_reg     <= '0;
                        control_arr_reg <= 1'b1;
                        state_reg       <= LOAD;
                    end
                end
                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end

    assign in_ready        = (state_reg == LOAD);
    assign busy            = (state_reg != LOAD) || (addr_reg != '0);
    assign out_valid       = out_valid_reg;
    assign out_timeout     = out_timeout_reg;
    assign out_result      = out_result_reg;
    assign core_r_enable   = r_enable_reg;
    assign core_controlArr = control_arr_reg;
    assign core_init_i     = '0;
    assign core_init_acc   = '0;
    assign core_wen_a      = wen_reg;
    assign core_wen_b      = wen_reg;
    assign core_addr_a     = waddr_reg;
    assign core_addr_b     = waddr_reg;
    assign core_wdata_a    = wdata_a_reg;
    assign core_wdata_b    = wdata_b_reg;

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Bench for dot_prod_feeder with a behavioural dot-product core stub and a
// reference sum computed directly from the pairs handed to the feeder.
module tb_dot_prod_feeder;

    localparam int N        = 1000;
    localparam int AW       = 10;
    localparam int DW       = 27;
    localparam int RW       = 64;
    localparam int TMO      = 16;
    localparam int STUB_LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_result;
    logic          out_timeout;
    logic          busy;
    logic          core_r_enable;
    logic          core_controlArr;
    logic [AW-1:0] core_init_i;
    logic [RW-1:0] core_init_acc;
    logic          core_wen_a;
    logic          core_wen_b;
    logic [AW-1:0] core_addr_a;
    logic [AW-1:0] core_addr_b;
    logic [DW-1:0] core_wdata_a;
    logic [DW-1:0] core_wdata_b;
    logic          core_w_enable;
    logic [RW-1:0] core_result;

    int n_cmp  = 0;
    int n_fail = 0;
    int ja[N];
    int jb[N];

    dot_prod_feeder #(.N(N), .AW(AW), .DW(DW), .RW(RW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_timeout(out_timeout), .busy(busy),
        .core_r_enable(core_r_enable), .core_controlArr(core_controlArr),
        .core_init_i(core_init_i), .core_init_acc(core_init_acc),
        .core_wen_a(core_wen_a), .core_wen_b(core_wen_b),
        .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
        .core_wdata_a(core_wdata_a), .core_wdata_b(core_wdata_b),
        .core_w_enable(core_w_enable), .core_result(core_result)
    );

    always #5 clk = ~clk;

    // Core stub: arrays written while parked, sum produced STUB_LAT cycles after release.
    logic [DW-1:0] a_mem[N];
    logic [DW-1:0] b_mem[N];
    int            stub_cnt  = 0;
    logic          stub_wen  = 1'b0;
    logic [RW-1:0] stub_res  = '0;
    bit            stub_hang = 1'b0;

    function automatic longint core_sum();
        longint s = 0;
        for (int i = 0; i < N; i++)
            s += longint'($signed(a_mem[i])) * longint'($signed(b_mem[i]));
        return s;
    endfunction

    always @(posedge clk) begin
        if (core_controlArr === 1'b1 && core_wen_a === 1'b1 && int'(core_addr_a) < N)
            a_mem[core_addr_a] <= core_wdata_a;
        if (core_controlArr === 1'b1 && core_wen_b === 1'b1 && int'(core_addr_b) < N)
            b_mem[core_addr_b] <= core_wdata_b;
        if (core_r_enable !== 1'b0) begin
            stub_cnt <= 0;
            stub_wen <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == STUB_LAT && !stub_hang) begin
                stub_wen <= 1'b1;
                stub_res <= RW'(core_sum());
            end
        end
    end

    assign core_w_enable = stub_wen;
    assign core_result   = stub_res;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Offer pairs ja/jb[0..count-1]; every accepted pair must appear as one core write.
    task automatic send_pairs(input int count, input int valid_pct, input bit toggle,
                              output longint exp_sum);
        int k = 0;
        int guard = 0;
        bit v, acc;
        exp_sum = 0;
        while (k < count && guard < 20 * N) begin
            guard++;
            v = toggle ? guard[0] : ($urandom_range(0, 99) < valid_pct);
            in_valid = v;
            in_a = DW'(ja[k]);
            in_b = DW'(jb[k]);
            acc = v && (in_ready === 1'b1);
            @(posedge clk); #1;
            n_cmp++;
            if (acc) begin
                if (core_wen_a !== 1'b1 || core_wen_b !== 1'b1 ||
                    core_addr_a !== AW'(k) || core_addr_b !== AW'(k) ||
                    core_wdata_a !== DW'(ja[k]) || core_wdata_b !== DW'(jb[k])) begin
                    n_fail++;
                    $display("FAIL write[%0d]: wen=%b/%b addr=%0d/%0d wdata=%h/%h, required wen=1/1 addr=%0d wdata=%h/%h",
                             k, core_wen_a, core_wen_b, core_addr_a, core_addr_b,
                             core_wdata_a, core_wdata_b, k, DW'(ja[k]), DW'(jb[k]));
                end
                exp_sum += longint'(ja[k]) * longint'(jb[k]);
                k++;
            end else if (core_wen_a !== 1'b0 || core_wen_b !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_wen[%0d]: wen=%b/%b, required 0/0", k, core_wen_a, core_wen_b);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (k != count) begin
            n_fail++;
            $display("FAIL send_bound: accepted %0d pairs, required %0d", k, count);
        end
    endtask

    // Wait for the result, optionally stall the consumer, then take it.
    task automatic get_result(input longint exp, input bit exp_tmo, input int hold,
                              input int exp_lat);
        int cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL in_ready_run: in_ready=%b at cycle %0d, required 0", in_ready, cyc);
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2 && out_valid !== 1'b1) begin
                n_cmp++;
                if (core_r_enable !== 1'b0 || core_controlArr !== 1'b0 || core_wen_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL run_outputs: r_enable=%b controlArr=%b wen=%b, required 0/0/0",
                             core_r_enable, core_controlArr, core_wen_a);
                end
            end
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL result_bound: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
        end
        if (exp_lat > 0) begin
            n_cmp++;
            if (cyc != exp_lat) begin
                n_fail++;
                $display("FAIL result_latency: %0d cycles, required %0d", cyc, exp_lat);
            end
        end
        n_cmp++;
        if (out_result !== RW'(exp) || out_timeout !== exp_tmo || core_r_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL result: result=%0d timeout=%b r_enable=%b, required result=%0d timeout=%b r_enable=1",
                     $signed(out_result), out_timeout, core_r_enable, exp, exp_tmo);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_result !== RW'(exp) || out_timeout !== exp_tmo ||
                in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%b result=%0d timeout=%b in_ready=%b, required 1/%0d/%b/0",
                         h, out_valid, $signed(out_result), out_timeout, in_ready, exp, exp_tmo);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_timeout !== 1'b0 || in_ready !== 1'b1 ||
            core_controlArr !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release: valid=%b timeout=%b in_ready=%b controlArr=%b busy=%b, required 0/0/1/1/0",
                     out_valid, out_timeout, in_ready, core_controlArr, busy);
        end
        $display("job done: result=%0d timeout=%b latency=%0d", $signed(out_result), exp_tmo, cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_timeout !== 1'b0 || out_result !== '0 ||
            core_r_enable !== 1'b1 || core_controlArr !== 1'b1 || core_wen_a !== 1'b0 ||
            core_wen_b !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
            core_init_i !== '0 || core_init_acc !== '0) begin
            n_fail++;
            $display("FAIL reset: valid=%b tmo=%b result=%h r_en=%b ctl=%b wen=%b/%b busy=%b in_ready=%b init=%h/%h, required 0/0/0/1/1/0/0/0/1/0/0",
                     out_valid, out_timeout, out_result, core_r_enable, core_controlArr,
                     core_wen_a, core_wen_b, busy, in_ready, core_init_i, core_init_acc);
        end
        rst_n = 1'b1;
        $display("reset checked");
    endtask

    task automatic test_ramp();
        longint s;
        for (int i = 0; i < N; i++) begin ja[i] = i + 1; jb[i] = 2; end
        send_pairs(N, 100, 1'b0, s);
        n_cmp++;
        if (s != 64'd1001000) begin
            n_fail++;
            $display("FAIL ramp_model: model sum %0d, required 1001000", s);
        end
        get_result(64'd1001000, 1'b0, 0, 0);
    endtask

    task automatic test_toggle_valid();
        longint s;
        for (int i = 0; i < N; i++) begin ja[i] = -3; jb[i] = 5; end
        send_pairs(N, 0, 1'b1, s);
        get_result(-64'sd15000, 1'b0, 0, 0);
    endtask

    task automatic test_backpressure();
        longint s;
        for (int i = 0; i < N; i++) begin ja[i] = i % 7 - 3; jb[i] = 11; end
        send_pairs(N, 100, 1'b0, s);
        get_result(s, 1'b0, 20, 0);
    endtask

    task automatic test_timeout();
        longint s;
        stub_hang = 1'b1;
        for (int i = 0; i < N; i++) begin ja[i] = 9; jb[i] = 9; end
        send_pairs(N, 100, 1'b0, s);
        get_result(64'd0, 1'b1, 3, TMO);
        stub_hang = 1'b0;
    endtask

    task automatic test_mid_reset();
        longint s;
        for (int i = 0; i < N; i++) begin ja[i] = 77; jb[i] = -5; end
        send_pairs(500, 100, 1'b0, s);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_partial: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || core_wen_a !== 1'b0 || core_r_enable !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b wen=%b r_en=%b in_ready=%b, required 0/0/1/1",
                     busy, core_wen_a, core_r_enable, in_ready);
        end
        for (int i = 0; i < N; i++) begin ja[i] = 1; jb[i] = 1; end
        send_pairs(N, 100, 1'b0, s);
        get_result(64'd1000, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        longint s;
        for (int i = 0; i < N; i++) begin ja[i] = 1; jb[i] = 1; end
        send_pairs(N, 100, 1'b0, s);
        get_result(64'd1000, 1'b0, 0, 0);
        for (int i = 0; i < N; i++) begin ja[i] = 1; jb[i] = -1; end
        send_pairs(N, 100, 1'b0, s);
        get_result(-64'sd1000, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        longint s;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < N; i++) begin
                ja[i] = int'($urandom_range(0, 2097151)) - 1048576;
                jb[i] = int'($urandom_range(0, 2097151)) - 1048576;
            end
            ja[0] = -(1 << (DW - 1));
            jb[0] = (1 << (DW - 1)) - 1;
            send_pairs(N, 70, 1'b0, s);
            get_result(s, 1'b0, int'($urandom_range(0, 5)), 0);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        test_reset();
        test_ramp();
        test_toggle_valid();
        test_backpressure();
        test_timeout();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
